irq_sequencer: RTL and testbench
================================

# irq_sequencer

CPU-side consumer of the interrupt controller's `irq_assert` line. It samples the level request, waits for a safe instruction boundary, redirects fetch to a fixed vector, and saves the return PC and flags on a small hardware stack. On return-from-interrupt it restores them and guarantees that one instruction of the interrupted code executes before the next entry. It sits between the interrupt controller and the core's fetch/flags logic.

## Interface
- `VECTOR`, 16'h0004, handler entry address
- `NEST_DEPTH`, 2, save-stack depth (1..3); used only with nesting compiled in

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `irq`  in  1  level request from the interrupt controller
- `boundary`  in  1  core is at an instruction boundary this cycle; `pc_next` is valid and fetch may be redirected
- `pc_next`  in  16  address of the next instruction
- `flags_in`  in  4  current core flags
- `rti`  in  1  one-cycle pulse: core is retiring a return-from-interrupt
- `ie_set`, `ie_clr`  in  1 each  EI/DI instruction pulses
- `take`  out  1  comb pulse: fetch from `vector_pc` next
- `ret`  out  1  comb pulse: fetch from `vector_pc` next and load `flags_out`
- `vector_pc`  out  16  restored PC when `ret` is high, otherwise `VECTOR`
- `flags_out`  out  4  restored flags; valid when `ret` is high, 0 otherwise
- `ie`  out  1  global interrupt enable (registered)
- `depth`  out  2  current nesting level

## Operation
- FSM states are IDLE, PEND, HANDLER and GUARD. The state register, `ie`, `depth` and the stack are registered; `take`, `ret`, `vector_pc` and `flags_out` are combinational.
- **IDLE:** `irq && ie` moves to PEND.
- **PEND:**
  - `take = boundary && irq && ie`.
  - If `irq` or `ie` is low, return to IDLE. A dropped request is discarded silently.
- **On take:**
  - `stack[depth] <= {pc_next, flags_in}`.
  - `depth <= depth+1`.
  - `ie <= 0`.
  - State moves to HANDLER.
- **HANDLER:**
  - `rti` with `depth>0`: `ret=1`, `vector_pc`/`flags_out` = `stack[depth-1]`, `depth <= depth-1`, `ie <= 1`.
  - Next state is GUARD if the new depth is 0, otherwise HANDLER.
- **GUARD:** the first `boundary` after entry is consumed with no take. Then go to IDLE, or directly to PEND if `irq && ie`.
- **`ie` update:**
  - `ie_clr` beats `ie_set`.
  - Entry and return forcing of `ie` beats both.
- **Priority and boundary cases:**
  - `rti` and `boundary` in the same cycle: `rti` wins, no take.
  - `rti` with `depth==0` or outside HANDLER: ignored.
  - `take` uses the registered `ie`. `ie_clr` in the take cycle does not block the take.
  - `reset` mid-handler: abandon all state, clear the stack.
- **Reset values:** state IDLE, `ie=0`, `depth=0`, stack 0, `take=0`, `ret=0`, `vector_pc=VECTOR`, `flags_out=0`.

## Timing
- `irq` rises in cycle N → PEND in N+1. Earliest `take` is N+1, coincident with `boundary`.
- `take`/`ret` are asserted in the same cycle as `boundary`/`rti`. The core redirects fetch on that edge.
- `depth`, `ie` and the stack update on the edge that ends the `take`/`ret` cycle.
- After `ret` to depth 0, at least one `boundary` passes without a take. Minimum cycles between `ret` and the next `take` = two boundaries.
- `take` and `ret` are never high in the same cycle.

## Configuration
- `IRQ_NESTING_EN` defined:
  - In HANDLER, `boundary && irq && ie && depth<NEST_DEPTH` produces `take`, pushes a frame and increments `depth`.
  - Software re-enables nesting with EI.
- `IRQ_NESTING_EN` undefined:
  - Stack depth is fixed at 1.
  - In HANDLER, `ie` still tracks EI/DI, but no take occurs until `depth` returns to 0.
  - `NEST_DEPTH` is ignored.

## Test plan
- **Basic entry/return:** `ie` set; `irq` high; `boundary` with `pc_next=16'h1234`, `flags_in=4'hA` → `take=1`, `vector_pc=16'h0004`, then `depth=1`, `ie=0`. Then `rti` → `ret=1`, `vector_pc=16'h1234`, `flags_out=4'hA`, `depth=0`, `ie=1`.
- **Guard:** `irq` held high across `rti` → the first following `boundary` gives `take=0`; the second `boundary` gives `take=1`.
- **Spurious request:** `irq` pulses high for one cycle with no `boundary` → PEND then IDLE, no `take`. `ie=0` with `irq` high → never `take`.
- **Priority:**
  - `rti` and `boundary` together in HANDLER → `ret=1`, `take=0`.
  - `ie_set` and `ie_clr` together → `ie=0`.
- **Nesting (macro on):**
  - EI in handler, second `irq`/`boundary` at `pc_next=16'h0010` → `depth=2`.
  - Two `rti` pulses return `16'h0010`, then the original PC.
  - Macro off: same stimulus → `depth` stays 1, no second `take`.
- **Reset:** `reset` asserted in HANDLER at `depth=1` → `depth=0`, `ie=0`, IDLE. A subsequent `rti` is ignored.

Source files
------------

// File: rtl/irq_sequencer.sv
// irq_sequencer
//   Consumes the interrupt controller's level request, waits for an
//   instruction boundary, redirects fetch to VECTOR and pushes the return
//   PC and flags onto a small hardware stack. On return-from-interrupt the
//   frame is popped and one interrupted instruction is guaranteed to run
//   before the next entry.
//
//   Optional feature: define IRQ_NESTING_EN to allow nested entries from
//   HANDLER up to NEST_DEPTH frames. Without it the stack is one frame deep.
//
// Parameters
//   VECTOR      handler entry address
//   NEST_DEPTH  save-stack depth (1..3), only meaningful with nesting
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   irq                 level request from the interrupt controller
//   boundary            core is at an instruction boundary, pc_next valid
//   pc_next, flags_in   return address / flags captured on entry
//   rti                 return-from-interrupt retire pulse
//   ie_set, ie_clr      EI / DI pulses
//   take                comb: fetch from vector_pc next (entry)
//   ret                 comb: fetch from vector_pc next and load flags_out
//   vector_pc           restored PC while ret, else VECTOR
//   flags_out           restored flags while ret, else 0
//   ie                  registered global interrupt enable
//   depth               current nesting level
module irq_sequencer #(
  parameter logic [15:0] VECTOR     = 16'h0004,
  parameter int unsigned NEST_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        boundary,
  input  logic [15:0] pc_next,
  input  logic [3:0]  flags_in,
  input  logic        rti,
  input  logic        ie_set,
  input  logic        ie_clr,
  output logic        take,
  output logic        ret,
  output logic [15:0] vector_pc,
  output logic [3:0]  flags_out,
  output logic        ie,
  output logic [1:0]  depth
);

`ifdef IRQ_NESTING_EN
  localparam bit NEST_EN = 1'b1;
`else
  localparam bit NEST_EN = 1'b0;
`endif

  // Frame limit: one frame when nesting is compiled out.
  localparam logic [1:0] NEST_LIMIT = NEST_EN ? NEST_DEPTH[1:0] : 2'd1;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    HANDLER,
    GUARD
  } state_t;

  state_t      state, state_next;
  logic [19:0] stack [4];
  logic [1:0]  top_idx;
  logic [19:0] top_frame;

  assign top_idx   = depth - 2'd1;
  assign top_frame = stack[top_idx];

  always_comb begin
    state_next = state;
    take       = 1'b0;
    ret        = 1'b0;
    vector_pc  = VECTOR;
    flags_out  = '0;
    case (state)
      IDLE: begin
        if (irq && ie) state_next = PEND;
      end
      PEND: begin
        if (!(irq && ie)) begin
          state_next = IDLE;
        end else if (boundary) begin
          take       = 1'b1;
          state_next = HANDLER;
        end
      end
      HANDLER: begin
        // rti has priority over a coincident boundary.
        if (rti && depth != 2'd0) begin
          ret        = 1'b1;
          vector_pc  = top_frame[19:4];
          flags_out  = top_frame[3:0];
          state_next = (depth == 2'd1) ? GUARD : HANDLER;
        end else if (NEST_EN && boundary && irq && ie && depth < NEST_LIMIT) begin
          take = 1'b1;
        end
      end
      GUARD: begin
        // First boundary after the final return is consumed without a take.
        if (boundary) state_next = (irq && ie) ? PEND : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ie    <= 1'b0;
      depth <= '0;
      for (int unsigned i = 0; i < 4; i++) stack[i] <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        stack[depth] <= {pc_next, flags_in};
        depth        <= depth + 2'd1;
        ie           <= 1'b0;
      end else if (ret) begin
        depth <= depth - 2'd1;
        ie    <= 1'b1;
      end else if (ie_clr) begin
        ie <= 1'b0;
      end else if (ie_set) begin
        ie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq, boundary, rti, ie_set, ie_clr;
  logic [15:0] pc_next;
  logic [3:0]  flags_in;
  logic        take, ret, ie;
  logic [15:0] vector_pc;
  logic [3:0]  flags_out;
  logic [1:0]  depth;

  int checks = 0;
  int fails  = 0;

  irq_sequencer #(.VECTOR(16'h0004), .NEST_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .irq(irq), .boundary(boundary),
    .pc_next(pc_next), .flags_in(flags_in), .rti(rti),
    .ie_set(ie_set), .ie_clr(ie_clr), .take(take), .ret(ret),
    .vector_pc(vector_pc), .flags_out(flags_out), .ie(ie), .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, irq, bnd, rti, set, clr;
    logic [15:0] pc;
    logic [3:0]  fl;
  } stim_t;

  typedef struct packed {
    logic take, ret;
    logic [15:0] vpc;
    logic [3:0]  fl;
    logic ie;
    logic [1:0]  depth;
  } exp_t;

  exp_t sb[$];

  function automatic stim_t S(input logic r, i, b, t, se, c,
                              input logic [15:0] p, input logic [3:0] f);
    S = {r, i, b, t, se, c, p, f};
  endfunction

  function automatic exp_t E(input logic tk, rt, input logic [15:0] v,
                             input logic [3:0] f, input logic e, input logic [1:0] d);
    E = {tk, rt, v, f, e, d};
  endfunction

  task automatic apply(input stim_t s);
    reset    = s.rst;
    irq      = s.irq;
    boundary = s.bnd;
    rti      = s.rti;
    ie_set   = s.set;
    ie_clr   = s.clr;
    pc_next  = s.pc;
    flags_in = s.fl;
  endtask

  task automatic do_reset();
    apply(S(1, 0, 0, 0, 0, 0, 16'h0, 4'h0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    apply(S(1, 0, 0, 0, 0, 0, 16'h0, 4'h0));
    repeat (2) @(posedge clk);
    #1;
    st.push_back(S(1, 1, 0, 0, 1, 0, 16'h0, 4'h0)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(1, 1, 1, 1, 1, 0, 16'h0, 4'h0)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 16'h0, 4'h0)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = E(take, ret, vector_pc, flags_out, ie, depth); want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset[%0d]: got {take,ret,vpc,flags,ie,depth}=%h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h1234, 4'hA)); ex.push_back(E(1, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 1));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 1, 16'h1234, 4'hA, 0, 1));
    st.push_back(S(0, 0, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = E(take, ret, vector_pc, flags_out, ie, depth); want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL basic[%0d]: got {take,ret,vpc,flags,ie,depth}=%h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_guard();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 1, 0, 16'h0100, 4'h3)); ex.push_back(E(1, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 1, 16'h0100, 4'h3, 0, 1));
    st.push_back(S(0, 1, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0150, 4'h4)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0200, 4'h5)); ex.push_back(E(1, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 1));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 1, 16'h0200, 4'h5, 0, 1));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = E(take, ret, vector_pc, flags_out, ie, depth); want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL guard[%0d]: got {take,ret,vpc,flags,ie,depth}=%h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_spurious();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 1, 0, 0, 0, 16'h0300, 4'h1)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0300, 4'h1)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 1, 0, 0, 0, 16'h0300, 4'h1)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 0, 0, 1, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0300, 4'h1)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0300, 4'h1)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = E(take, ret, vector_pc, flags_out, ie, depth); want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL spurious[%0d]: got {take,ret,vpc,flags,ie,depth}=%h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 0, 0, 0, 1, 1, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 1, 16'h0ABC, 4'h6)); ex.push_back(E(1, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 1));
    st.push_back(S(0, 1, 1, 1, 0, 1, 16'h0555, 4'hF)); ex.push_back(E(0, 1, 16'h0ABC, 4'h6, 1, 1));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 1, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = E(take, ret, vector_pc, flags_out, ie, depth); want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL priority[%0d]: got {take,ret,vpc,flags,ie,depth}=%h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nesting();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h1000, 4'h1)); ex.push_back(E(1, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 1));
`ifdef IRQ_NESTING_EN
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0010, 4'h2)); ex.push_back(E(1, 0, 16'h0004, 4'h0, 1, 1));
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 2));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0020, 4'h3)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 2));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 1, 16'h0010, 4'h2, 1, 2));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 1, 16'h1000, 4'h1, 1, 1));
`else
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0010, 4'h2)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 1));
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 1));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0020, 4'h3)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 1));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 1, 16'h1000, 4'h1, 1, 1));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
`endif
    st.push_back(S(0, 0, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = E(take, ret, vector_pc, flags_out, ie, depth); want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL nesting[%0d]: got {take,ret,vpc,flags,ie,depth}=%h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_handler();
    stim_t st[$]; exp_t ex[$]; exp_t got, want;
    do_reset();
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0777, 4'h9)); ex.push_back(E(1, 0, 16'h0004, 4'h0, 1, 0));
    st.push_back(S(1, 0, 0, 0, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 1));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 1, 1, 0, 0, 0, 16'h0888, 4'h7)); ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 0, 0, 0, 1, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 0, 0));
    st.push_back(S(0, 0, 0, 1, 0, 0, 16'h0, 4'h0));    ex.push_back(E(0, 0, 16'h0004, 4'h0, 1, 0));
    foreach (st[i]) begin
      apply(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = E(take, ret, vector_pc, flags_out, ie, depth); want = sb.pop_front();
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL reset_in_handler[%0d]: got {take,ret,vpc,flags,ie,depth}=%h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_guard();
    test_spurious();
    test_priority();
    test_nesting();
    test_reset_in_handler();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
